// File: rtl/dmem_arbiter_pkg.sv
// Shared types and helpers for the two-port DMEM arbiter: FSM state,
// byte-enable constants, sub-word merge and byte-to-word address mapping.
package dmem_arb_pkg;

  localparam int AW = 32;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } arb_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return merged;
  endfunction

  function automatic logic [31:0] word_idx(input logic [AW-1:0] addr);
    return 32'(addr >> 2);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the DMEM arbiter: request/command in, grant and
// completion response out.
import dmem_arb_pkg::*;

interface dmem_arbiter_if #(
  parameter int AW = dmem_arb_pkg::AW
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on contention the requester not served most
// recently wins; the pointer moves on every grant.
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q;
  logic last_d;

  // One-hot grant and pointer update
  always_comb begin
    gnt_o = 2'b00;
    if (advance_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end else begin
      gnt_o = 2'b00;
    end
    if (gnt_o != 2'b00) begin
      last_d = gnt_o[1];
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register; reset favours port 0 on the first conflict
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DMEM between two requesters; sub-word stores are
// done as read (grant cycle) then merged write (RMW_WR cycle).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int AW    = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_arbiter_if.slave m0,
  dmem_arbiter_if.slave m1,
  output logic [31:0]   dmem_addr_o,
  output logic [31:0]   dmem_wdata_o,
  output logic          dmem_we_o,
  input  logic [31:0]   dmem_rdata_i
);

  arb_state_t       state_q, state_d;
  logic             rmw_port_q, rmw_port_d;
  logic [31:0]      rmw_addr_q, rmw_addr_d;
  logic [31:0]      rmw_wdata_q, rmw_wdata_d;
  logic [31:0]      rmw_old_q, rmw_old_d;
  logic [3:0]       rmw_be_q, rmw_be_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [31:0]      rdata0_q, rdata0_d;
  logic [31:0]      rdata1_q, rdata1_d;

  logic [NPORT-1:0] req_s;
  logic [NPORT-1:0] gnt_s;
  logic             advance_s;
  logic             sel_s;
  logic             sel_we_s;
  logic [AW-1:0]    sel_addr_s;
  logic [31:0]      sel_wdata_s;
  logic [3:0]       sel_be_s;
  logic             full_st_s;
  logic             part_st_s;

  assign req_s     = {m1.req, m0.req};
  assign advance_s = (state_q == IDLE) && !rst_i;

  rr_arbiter2 u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_s),
    .advance_i (advance_s),
    .gnt_o     (gnt_s)
  );

  assign m0.gnt    = gnt_s[0];
  assign m1.gnt    = gnt_s[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

  // Command of the granted port and its store classification
  always_comb begin
    sel_s = gnt_s[1];
    if (sel_s) begin
      sel_we_s    = m1.we;
      sel_addr_s  = m1.addr;
      sel_wdata_s = m1.wdata;
      sel_be_s    = m1.be;
    end else begin
      sel_we_s    = m0.we;
      sel_addr_s  = m0.addr;
      sel_wdata_s = m0.wdata;
      sel_be_s    = m0.be;
    end
    full_st_s = sel_we_s && (sel_be_s == BE_FULL);
    part_st_s = sel_we_s && (sel_be_s != BE_FULL) && (sel_be_s != BE_NONE);
  end

  // DMEM port mux; empty and partial stores never write in the grant cycle
  always_comb begin
    dmem_addr_o  = 32'd0;
    dmem_wdata_o = 32'd0;
    dmem_we_o    = 1'b0;
    if (state_q == RMW_WR) begin
      dmem_addr_o  = rmw_addr_q;
      dmem_wdata_o = be_merge(rmw_old_q, rmw_wdata_q, rmw_be_q);
      dmem_we_o    = 1'b1;
    end else if (gnt_s != 2'b00) begin
      dmem_addr_o = word_idx(sel_addr_s);
      if (full_st_s) begin
        dmem_wdata_o = sel_wdata_s;
        dmem_we_o    = 1'b1;
      end else begin
        dmem_wdata_o = 32'd0;
        dmem_we_o    = 1'b0;
      end
    end else begin
      dmem_addr_o  = 32'd0;
      dmem_wdata_o = 32'd0;
      dmem_we_o    = 1'b0;
    end
  end

  // Next state, RMW latches and one-cycle response pulse
  always_comb begin
    state_d     = state_q;
    rmw_port_d  = rmw_port_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_old_d   = rmw_old_q;
    rmw_be_d    = rmw_be_q;
    rvalid_d    = 2'b00;
    rdata0_d    = 32'd0;
    rdata1_d    = 32'd0;
    case (state_q)
      IDLE: begin
        if (gnt_s == 2'b00) begin
          state_d = IDLE;
        end else if (part_st_s) begin
          state_d     = RMW_WR;
          rmw_port_d  = sel_s;
          rmw_addr_d  = word_idx(sel_addr_s);
          rmw_wdata_d = sel_wdata_s;
          rmw_old_d   = dmem_rdata_i;
          rmw_be_d    = sel_be_s;
        end else begin
          rvalid_d = sel_s ? 2'b10 : 2'b01;
          if (sel_we_s) begin
            rdata0_d = 32'd0;
            rdata1_d = 32'd0;
          end else if (sel_s) begin
            rdata1_d = dmem_rdata_i;
          end else begin
            rdata0_d = dmem_rdata_i;
          end
        end
      end
      RMW_WR: begin
        state_d  = IDLE;
        rvalid_d = rmw_port_q ? 2'b10 : 2'b01;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers; reset abandons any RMW in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      rmw_port_q  <= 1'b0;
      rmw_addr_q  <= 32'd0;
      rmw_wdata_q <= 32'd0;
      rmw_old_q   <= 32'd0;
      rmw_be_q    <= 4'h0;
      rvalid_q    <= 2'b00;
      rdata0_q    <= 32'd0;
      rdata1_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      rmw_port_q  <= rmw_port_d;
      rmw_addr_q  <= rmw_addr_d;
      rmw_wdata_q <= rmw_wdata_d;
      rmw_old_q   <= rmw_old_d;
      rmw_be_q    <= rmw_be_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

endmodule
